// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle over a 2*XLEN accumulator, with an IDLE/CALC/DONE sequencer.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  // One shift-add step: add multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[XLEN-1:1]};
  endfunction

  // One restoring-divide step: acc holds {remainder, dividend/quotient}.
  // Shift left, trial-subtract the divisor, keep the difference if non-negative.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] dvsr);
    logic [XLEN:0] top;
    logic [XLEN:0] diff;
    top  = acc[2*XLEN-1:XLEN-1];
    diff = top - {1'b0, dvsr};
    if (!diff[XLEN]) return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else             return {acc[2*XLEN-2:0], 1'b0};
  endfunction

  // Sign correction and result selection once the iteration completes.
  function automatic logic [XLEN-1:0] final_res(input logic [2:0] op,
                                                input logic [2*XLEN-1:0] acc,
                                                input logic sa, input logic sb);
    logic [2*XLEN-1:0] p;
    if (!op[2]) begin
      p = (sa ^ sb) ? (~acc + (2*XLEN)'(1)) : acc;
      return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end else if (!op[1]) begin
      return cond_neg(acc[XLEN-1:0], sa ^ sb);
    end else begin
      return cond_neg(acc[2*XLEN-1:XLEN], sa);
    end
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, dz, ovf, special, last, sa_in, sb_in;
  logic [XLEN-1:0]   special_res, mag_a_in, mag_b_in;
  logic [2*XLEN-1:0] acc_step;

  assign accept   = (state_q == IDLE) && start && !flush;
  assign dz       = funct3[2] && (b == '0);
  assign ovf      = funct3[2] && !funct3[0] && (a == SMIN) && (b == '1);
  assign special  = dz || ovf;
  assign sa_in    = a[XLEN-1] && (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign sb_in    = b[XLEN-1] && (funct3 inside {3'b001, 3'b100, 3'b110});
  assign mag_a_in = cond_neg(a, sa_in);
  assign mag_b_in = cond_neg(b, sb_in);
  assign last     = (cnt_q == CW'(XLEN-1));
  assign acc_step = op_q[2] ? div_step(acc_q, mag_b_q) : mul_step(acc_q, mag_a_q);

  // Divide-by-zero wins over overflow; both are decided from the raw operands.
  always_comb begin
    special_res = '0;
    if (dz)       special_res = funct3[1] ? a : '1;
    else if (ovf) special_res = funct3[1] ? '0 : SMIN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush outranks start and aborts an in-flight iteration.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  assign result = result_q;

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= funct3;
      mag_a_q <= mag_a_in;
      mag_b_q <= mag_b_in;
      sa_q    <= sa_in;
      sb_q    <= sb_in;
      cnt_q   <= '0;
      acc_q   <= funct3[2] ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
      if (special) result_q <= special_res;
    end else if (state_q == CALC && !flush) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + CW'(1);
      if (last) result_q <= final_res(op_q, acc_step, sa_q, sb_q);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of operations with
// hand-computed results and latencies, plus sequences for ignored start,
// flush in each state and reset in the middle of an iteration.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle start is presented; cycle k begins after posedge k.
  task automatic start_op(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = va; b = vb;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int first_done, done_cnt, busy_cnt;
    logic [31:0] res_seen;
    first_done = -1; done_cnt = 0; busy_cnt = 0; res_seen = 'x;
    start_op(v.f3, v.a, v.b);
    for (int k = 1; k <= v.lat + 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        if (first_done < 0) first_done = k;
        done_cnt++;
        res_seen = result;
      end
      if (busy) busy_cnt++;
    end
    chk($sformatf("v%0d_done_cycle", idx), 32'(first_done), 32'(v.lat));
    chk($sformatf("v%0d_done_pulses", idx), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'(v.lat - 1));
    chk($sformatf("v%0d_result", idx), res_seen, v.res);
  endtask

  vec_t vecs[16];

  initial begin
    int done_cnt;
    logic [31:0] held;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33}; // MUL 7*-3
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33}; // MULHU
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33}; // MULH -1*-1
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33}; // MULHSU -1*2
    vecs[4]  = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 33}; // MUL
    vecs[5]  = '{3'b001, 32'h40000000, 32'd4,        32'h00000001, 33}; // MULH 2^30*4
    vecs[6]  = '{3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 33}; // DIV -20/6
    vecs[7]  = '{3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 33}; // REM -20%6
    vecs[8]  = '{3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 33}; // DIV 20/-6
    vecs[9]  = '{3'b110, 32'd20,       32'hFFFFFFFA, 32'h00000002, 33}; // REM 20%-6
    vecs[10] = '{3'b101, 32'd100,      32'd7,        32'd14,       33}; // DIVU
    vecs[11] = '{3'b111, 32'd100,      32'd7,        32'd2,        33}; // REMU
    vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};  // DIVU /0
    vecs[13] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};  // REMU /0
    vecs[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};  // DIV ovf
    vecs[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};  // REM ovf

    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Start during CALC is ignored and must not disturb latched operands.
    start_op(3'b000, 32'd3, 32'd5);
    done_cnt = 0; held = 'x;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (done) begin done_cnt++; held = result; chk("ign_done_cycle", 32'(k), 32'd33); end
      start = (k == 5);
      if (k == 5) begin funct3 = 3'b101; a = 32'd9; b = 32'd0; end
    end
    chk("ign_done_pulses", 32'(done_cnt), 32'd1);
    chk("ign_result", held, 32'd15);

    // Flush in CALC: back to IDLE next cycle, no done, result held.
    start_op(3'b000, 32'd11, 32'd13);
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
      if (k == 10) chk("flush_busy_c10", 32'(busy), 32'd1);
      if (k == 11) chk("flush_busy_c11", 32'(busy), 32'd0);
      flush = (k == 10);
    end
    flush = 1'b0;
    chk("flush_no_done", 32'(done_cnt), 32'd0);
    chk("flush_result_held", result, 32'd15);

    // Flush in IDLE blocks a same-cycle start.
    start_op(3'b000, 32'd2, 32'd2);
    flush = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (done || busy) done_cnt++;
    end
    chk("flush_idle_blocks", 32'(done_cnt), 32'd0);

    // Flush in DONE does not suppress the pulse.
    start_op(3'b101, 32'd5, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    chk("flush_done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_idle", 32'(done), 32'd0);
    chk("flush_done_result", result, 32'hFFFFFFFF);

    // Reset mid-DIVU, then a fresh start completes normally.
    start_op(3'b101, 32'd100, 32'd7);
    done_cnt = 0; held = 'x;
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++; held = result;
        chk("rst_done_cycle", 32'(k), 32'd55);
      end
      if (k == 21) begin
        chk("rst_busy_c21", 32'(busy), 32'd0);
        chk("rst_done_c21", 32'(done), 32'd0);
        chk("rst_result_c21", result, 32'd0);
      end
      reset = (k == 20);
      if (k == 22) begin start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7; end
    end
    chk("rst_done_pulses", 32'(done_cnt), 32'd1);
    chk("rst_result", held, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL expose parameter XLEN, default 32, operand/result width.
REQ-002 SHALL expose port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL expose port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL expose port start  input  1  request to begin an M-extension operation.
REQ-005 SHALL expose port funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL expose port a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-007 SHALL expose port b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-008 SHALL expose port flush  input  1  abort the in-flight operation.
REQ-009 SHALL expose port busy  output  1  operation in flight; the pipeline stalls on it.
REQ-010 SHALL expose port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL expose port result  output  XLEN  operation result.

Function
REQ-012 SHALL implement a state machine with states IDLE, CALC, DONE.
REQ-013 SHALL accept start only in IDLE; start in CALC or DONE is ignored, and the latched operands are unchanged.
REQ-014 On an accepted start, SHALL latch funct3, |a|, |b| and the sign flags per op (signed for MULH/DIV/REM; a-only for MULHSU; none for MULHU/DIVU/REMU/MUL).
REQ-015 Normal path SHALL move IDLE->CALC; run exactly XLEN CALC cycles with a 0..XLEN-1 iteration counter; go CALC->DONE; then go DONE->IDLE.
REQ-016 With start accepted in cycle N, done SHALL be high in cycle N+XLEN+1 only (33-cycle latency at XLEN=32).
REQ-017 Multiply SHALL use an iterative shift-add over a 2*XLEN accumulator; the product is negated at DONE when the operand signs differ.
REQ-018 MUL SHALL return the low XLEN bits; MULH/MULHSU/MULHU SHALL return the high XLEN bits of the signed-corrected product.
REQ-019 Divide SHALL use iterative restoring division, one quotient bit per CALC cycle.
REQ-020 Quotient SHALL be negated when the dividend and divisor signs differ (signed ops); remainder SHALL take the sign of the dividend.
REQ-021 Divide by zero (b==0) SHALL take IDLE->DONE directly, with done in cycle N+1.
REQ-022 On divide by zero, DIV/DIVU SHALL return all ones; REM/REMU SHALL return a.
REQ-023 Signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF) SHALL take IDLE->DONE directly.
REQ-024 On signed overflow, DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-025 busy SHALL be 1 in CALC and 0 in IDLE and DONE; start is never accepted while busy is 1.
REQ-026 result SHALL be updated only on entry to DONE and held until the next entry to DONE.
REQ-027 flush in CALC SHALL return the block to IDLE next cycle, with no done pulse and result unchanged.
REQ-028 flush in DONE SHALL suppress nothing (done still pulses); flush in IDLE SHALL block acceptance of a same-cycle start.
REQ-029 flush SHALL take priority over start; reset SHALL take priority over flush and start.

Reset
REQ-030 On reset, SHALL enter IDLE and clear the counter, accumulator, latched operands and sign flags.
REQ-031 On reset, SHALL drive busy=0, done=0 and result=0.
REQ-032 Reset asserted mid-CALC SHALL abort with no done pulse and leave busy=0 from the next cycle.

Verification
REQ-033 MUL a=7, b=-3 (0xFFFFFFFD), start cycle 0 -> busy cycles 1-32, done in cycle 33, result=0xFFFFFFEB.
REQ-034 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0.
REQ-035 DIV a=-20, b=6 -> result=0xFFFFFFFD (-3); REM with the same operands -> result=0xFFFFFFFE (-2); each done in cycle 33.
REQ-036 DIVU a=5, b=0 -> done in cycle 1, result=0xFFFFFFFF; DIV a=0x80000000, b=-1 -> done in cycle 1, result=0x80000000.
REQ-037 start MUL; flush in cycle 10 -> IDLE in cycle 11, no done, result unchanged; a second start in cycle 5 is ignored.
REQ-038 reset in cycle 20 of a DIVU -> busy=0, done=0, result=0 from cycle 21; a new start in cycle 22 completes normally in cycle 55.
